ebi_read_responder: RTL and testbench
=====================================

EBI_READ_RESPONDER -- requirements
Module: ebi_read_responder

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, 15, max clk cycles waited for rd_valid; STATUS_BANK, 7, bank_select value served by internal status registers.
REQ-002 Ports SHALL be:
- clk  in  1  pixel clock; the block's single clock.
- reset  in  1  synchronous, active-high.
- EBI_AD  in  16  multiplexed address/data input from the pad.
- EBI_ALE  in  1  address latch enable, active-high, asynchronous.
- EBI_RE  in  1  read enable, active-low, asynchronous.
- bank_select  in  3  bank of the current access.
- ebi_ad_out  out  16  read data to the pad.
- ebi_ad_oe  out  1  pad output enable, high = FPGA drives bus.
- rd_req  out  1  one-cycle memory read strobe.
- rd_bank  out  3  bank for rd_req.
- rd_addr  out  15  word address for rd_req.
- rd_data  in  16  memory read data.
- rd_valid  in  1  rd_data valid, 1..N cycles after rd_req.
- line_number  in  10  current sy.
- frame_pulse  in  1  one-cycle end-of-frame strobe.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 EBI_ALE, EBI_RE and bank_select SHALL each pass through a 2-flop synchronizer; EBI_AD SHALL be delayed 2 flops so it stays aligned with synchronized ALE.
REQ-004 The address SHALL be captured from delayed EBI_AD[14:0] on the synchronized ALE falling edge.
REQ-005 The FSM SHALL have states IDLE, ADDR, FETCH, DRIVE, TURN.
REQ-006 IDLE->ADDR on ALE falling edge; ADDR->FETCH on synchronized RE low.
REQ-007 On entering FETCH, rd_req SHALL pulse for exactly one cycle, with rd_bank and rd_addr equal to the latched values, unless bank == STATUS_BANK.
REQ-008 For STATUS_BANK no rd_req SHALL issue; data SHALL be ready the next cycle:
- addr 0: {6'b0, line_number}
- addr 1: frame_count
- addr 2: {14'b0, timeout_sticky, in_vblank}
- any other addr: 16'h0000
REQ-009 FETCH->DRIVE on rd_valid; ebi_ad_out SHALL register rd_data and ebi_ad_oe SHALL rise in the same cycle.
REQ-010 If rd_valid is absent for TIMEOUT_CYCLES cycles after rd_req, DRIVE SHALL be entered with ebi_ad_out = 16'hDEAD and timeout_sticky set.
- timeout_sticky SHALL clear only on a STATUS_BANK addr 2 read.
REQ-011 In DRIVE, ebi_ad_out SHALL hold stable until synchronized RE goes high, then go to TURN.
REQ-012 In TURN, ebi_ad_oe SHALL be low for exactly 1 cycle, then IDLE.
REQ-013 If RE rises while in FETCH, the read SHALL abort to IDLE, oe SHALL never assert, and a later rd_valid SHALL be ignored.
REQ-014 An ALE rising edge in any non-IDLE state SHALL drop ebi_ad_oe on the next edge and go to IDLE; the following ALE fall SHALL proceed normally.
REQ-015 Total latency SHALL be: RE low at pin -> oe high = 2 sync + 1 FETCH entry + memory latency + 1 cycles.
REQ-016 frame_count SHALL be 16 bits, increment on frame_pulse, and wrap 16'hFFFF->16'h0000.
REQ-017 in_vblank SHALL be set by frame_pulse and cleared when line_number == 0.
REQ-018 frame_pulse during a status read SHALL not change already-captured data.
REQ-019 ebi_ad_oe SHALL be high only in DRIVE.

Reset
REQ-020 On reset the block SHALL go to IDLE and clear: ebi_ad_oe, rd_req, ebi_ad_out (16'h0000), rd_addr, rd_bank, busy, frame_count, timeout_sticky, in_vblank and all synchronizers.
REQ-021 Reset asserted during DRIVE SHALL deassert ebi_ad_oe at the next clk edge.

Structure
REQ-022 A shared package ebi_pkg SHALL hold the FSM state enum, bank encodings (OAM=0, SPRITE=1, TILE=2, PALETTE=3, TAM=4, STATUS=7), the status address constants and the 16'hDEAD error word.
REQ-023 One sub-module, ebi_sync (2-flop synchronizer, width-parameterized), SHALL be instantiated for the control and bank signals.

Verification
REQ-024 The bench SHALL cover:
- bank 3, addr 0x0012, RE low; memory returns 16'h0F0A after 2 cycles -> one rd_req with rd_addr = 0x0012, rd_bank = 3; ebi_ad_out = 16'h0F0A; oe high until RE rises, then one TURN cycle.
- bank 7, addr 0, line_number = 10'd300 -> 16'h012C, no rd_req.
- rd_valid never returns -> 16'hDEAD after 15 cycles; next status addr 2 read returns bit1 = 1; a second read returns bit1 = 0.
- RE released 1 cycle after rd_req, rd_valid arrives 3 cycles later -> oe stays 0, FSM returns to IDLE.
- 65536 frame_pulses from reset -> status addr 1 reads 16'h0000; one more pulse -> 16'h0001.
- reset asserted in DRIVE -> oe 0 and ebi_ad_out 16'h0000 at the next edge.

Source files
------------

// File: rtl/ebi_pkg.sv
// Shared definitions for the EBI read responder: FSM states, bank codes,
// status register map and the word returned when memory never answers.
package ebi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRIVE = 3'd3,
        ST_TURN  = 3'd4
    } ebi_state_e;

    localparam logic [2:0] BANK_OAM     = 3'd0;
    localparam logic [2:0] BANK_SPRITE  = 3'd1;
    localparam logic [2:0] BANK_TILE    = 3'd2;
    localparam logic [2:0] BANK_PALETTE = 3'd3;
    localparam logic [2:0] BANK_TAM     = 3'd4;
    localparam logic [2:0] BANK_STATUS  = 3'd7;

    localparam logic [14:0] STAT_ADDR_LINE  = 15'd0;
    localparam logic [14:0] STAT_ADDR_FRAME = 15'd1;
    localparam logic [14:0] STAT_ADDR_FLAGS = 15'd2;

    localparam logic [15:0] EBI_ERR_WORD = 16'hDEAD;

    function automatic logic [15:0] status_word(
        input logic [14:0] addr,
        input logic [9:0]  line,
        input logic [15:0] frames,
        input logic        sticky,
        input logic        vblank
    );
        logic [15:0] word;
        case (addr)
            STAT_ADDR_LINE:  word = {6'b0, line};
            STAT_ADDR_FRAME: word = frames;
            STAT_ADDR_FLAGS: word = {14'b0, sticky, vblank};
            default:         word = 16'h0000;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/ebi_sync.sv
// Two-flop synchronizer for asynchronous pad inputs; clears to zero on reset.
module ebi_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ebi_read_responder.sv
// Answers host reads on a multiplexed async external bus, either from the
// memory read port or from internal status registers in STATUS_BANK.
module ebi_read_responder
    import ebi_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 15,
    parameter logic [2:0] STATUS_BANK    = 3'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] EBI_AD,
    input  logic        EBI_ALE,
    input  logic        EBI_RE,
    input  logic [2:0]  bank_select,
    output logic [15:0] ebi_ad_out,
    output logic        ebi_ad_oe,
    output logic        rd_req,
    output logic [2:0]  rd_bank,
    output logic [14:0] rd_addr,
    input  logic [15:0] rd_data,
    input  logic        rd_valid,
    input  logic [9:0]  line_number,
    input  logic        frame_pulse,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]  ctl_s;
    logic        ale_s;
    logic        re_s;
    logic [2:0]  bank_s;

    ebi_sync #(.WIDTH(2)) u_ctl_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({EBI_ALE, EBI_RE}),
        .q     (ctl_s)
    );

    ebi_sync #(.WIDTH(3)) u_bank_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bank_select),
        .q     (bank_s)
    );

    assign ale_s = ctl_s[1];
    assign re_s  = ctl_s[0];

    // Address path gets the same two-cycle delay as ALE so the latched
    // address corresponds to the synchronized falling edge.
    logic [15:0] ad_dly1_q;
    logic [15:0] ad_dly2_q;
    logic        ale_prev_q;
    logic        ad_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            ad_dly1_q  <= '0;
            ad_dly2_q  <= '0;
            ale_prev_q <= 1'b0;
        end else begin
            ad_dly1_q  <= EBI_AD;
            ad_dly2_q  <= ad_dly1_q;
            ale_prev_q <= ale_s;
        end
    end

    assign ad_unused = ad_dly2_q[15];

    logic ale_fall;
    logic ale_rise;

    assign ale_fall = ale_prev_q & ~ale_s;
    assign ale_rise = ~ale_prev_q & ale_s;

    ebi_state_e  state_q,  state_d;
    logic [14:0] addr_q,   addr_d;
    logic [2:0]  bank_q,   bank_d;
    logic        rd_req_q, rd_req_d;
    logic [14:0] rd_addr_q, rd_addr_d;
    logic [2:0]  rd_bank_q, rd_bank_d;
    logic [15:0] out_q,    out_d;
    logic        oe_q,     oe_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        sticky_q, sticky_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        vblank_q, vblank_d;

    always_comb begin
        frame_count_d = frame_count_q;
        vblank_d      = vblank_q;
        if (frame_pulse) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        // A new frame pulse wins over a simultaneous line-0 clear.
        if (frame_pulse) begin
            vblank_d = 1'b1;
        end else if (line_number == 10'd0) begin
            vblank_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bank_d    = bank_q;
        rd_req_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;

        if (state_q != ST_IDLE && ale_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ale_fall) begin
                        addr_d  = ad_dly2_q[14:0];
                        bank_d  = bank_s;
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!re_s) begin
                        state_d = ST_FETCH;
                        cnt_d   = '0;
                        if (bank_q != STATUS_BANK) begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = addr_q;
                            rd_bank_d = bank_q;
                        end
                    end
                end
                ST_FETCH: begin
                    if (re_s) begin
                        state_d = ST_IDLE;
                    end else if (bank_q == STATUS_BANK) begin
                        out_d   = status_word(addr_q, line_number, frame_count_q,
                                              sticky_q, vblank_q);
                        state_d = ST_DRIVE;
                        if (addr_q == STAT_ADDR_FLAGS) begin
                            sticky_d = 1'b0;
                        end
                    end else if (rd_valid) begin
                        out_d   = rd_data;
                        state_d = ST_DRIVE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        out_d    = EBI_ERR_WORD;
                        sticky_d = 1'b1;
                        state_d  = ST_DRIVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (re_s) begin
                        state_d = ST_TURN;
                    end
                end
                ST_TURN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        oe_d = (state_d == ST_DRIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            bank_q        <= '0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            rd_bank_q     <= '0;
            out_q         <= 16'h0000;
            oe_q          <= 1'b0;
            cnt_q         <= '0;
            sticky_q      <= 1'b0;
            frame_count_q <= 16'h0000;
            vblank_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            bank_q        <= bank_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            rd_bank_q     <= rd_bank_d;
            out_q         <= out_d;
            oe_q          <= oe_d;
            cnt_q         <= cnt_d;
            sticky_q      <= sticky_d;
            frame_count_q <= frame_count_d;
            vblank_q      <= vblank_d;
        end
    end

    assign ebi_ad_out = out_q;
    assign ebi_ad_oe  = oe_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign rd_bank    = rd_bank_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ebi_read_responder.sv
// Directed bench for ebi_read_responder with a small latency-programmable
// memory model on the read port.
module tb_ebi_read_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] EBI_AD = 16'h0000;
    logic        EBI_ALE = 1'b0;
    logic        EBI_RE = 1'b1;
    logic [2:0]  bank_select = 3'd0;
    logic [15:0] ebi_ad_out;
    logic        ebi_ad_oe;
    logic        rd_req;
    logic [2:0]  rd_bank;
    logic [14:0] rd_addr;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_valid = 1'b0;
    logic [9:0]  line_number = 10'd0;
    logic        frame_pulse = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    ebi_read_responder #(
        .TIMEOUT_CYCLES (15),
        .STATUS_BANK    (3'd7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .EBI_AD      (EBI_AD),
        .EBI_ALE     (EBI_ALE),
        .EBI_RE      (EBI_RE),
        .bank_select (bank_select),
        .ebi_ad_out  (ebi_ad_out),
        .ebi_ad_oe   (ebi_ad_oe),
        .rd_req      (rd_req),
        .rd_bank     (rd_bank),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .line_number (line_number),
        .frame_pulse (frame_pulse),
        .busy        (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Memory model: rd_valid pulses mem_latency cycles after rd_req; 0 = never.
    int          mem_latency = 2;
    logic [15:0] mem_data = 16'h0000;
    int          mem_cnt = 0;
    int          rdreq_count = 0;
    logic [14:0] last_addr = '0;
    logic [2:0]  last_bank = '0;

    always @(negedge clk) begin
        rd_valid = 1'b0;
        if (rd_req === 1'b1) begin
            rdreq_count++;
            last_addr = rd_addr;
            last_bank = rd_bank;
            mem_cnt   = mem_latency;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rd_valid = 1'b1;
                rd_data  = mem_data;
            end
        end
    end

    task automatic issue_addr(input logic [2:0] b, input logic [14:0] a);
        @(negedge clk);
        EBI_AD      = {1'b0, a};
        bank_select = b;
        EBI_ALE     = 1'b1;
        repeat (4) @(negedge clk);
        EBI_ALE = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_oe(output int lat, output bit ok);
        EBI_RE = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ebi_ad_oe === 1'b1) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_read(input string tag, input logic [15:0] exp);
        bit ok;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_hold_oe"}, 32'(ebi_ad_oe), 32'd1);
            check({tag, "_hold_data"}, 32'(ebi_ad_out), 32'(exp));
        end
        EBI_RE = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ebi_ad_oe === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_oe_drop"}, 32'(ok), 32'd1);
        check({tag, "_turn_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_oe"}, 32'(ebi_ad_oe), 32'd0);
    endtask

    task automatic full_read(input string tag, input logic [2:0] b, input logic [14:0] a,
                             input logic [15:0] exp, input int exp_lat, input int exp_req);
        int lat;
        bit ok;
        int req0;
        req0 = rdreq_count;
        issue_addr(b, a);
        check({tag, "_addr_busy"}, 32'(busy), 32'd1);
        wait_oe(lat, ok);
        check({tag, "_oe_seen"}, 32'(ok), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(ebi_ad_out), 32'(exp));
        check({tag, "_rd_reqs"}, 32'(rdreq_count - req0), 32'(exp_req));
        finish_read(tag, exp);
    endtask

    initial begin
        int  lat;
        bit  ok;
        bit  oe_seen;
        int  req0;

        repeat (3) @(negedge clk);
        check("rst_oe", 32'(ebi_ad_oe), 32'd0);
        check("rst_out", 32'(ebi_ad_out), 32'h0000);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_rd_addr", 32'(rd_addr), 32'd0);

        // Palette read, memory answers 2 cycles after the strobe.
        mem_latency = 2;
        mem_data    = 16'h0F0A;
        full_read("pal", 3'd3, 15'h0012, 16'h0F0A, 6, 1);
        check("pal_rd_addr", 32'(last_addr), 32'h0012);
        check("pal_rd_bank", 32'(last_bank), 32'd3);

        // ALE rising while driving aborts; the next address phase works.
        mem_data = 16'hBEEF;
        issue_addr(3'd1, 15'h0100);
        wait_oe(lat, ok);
        check("ale_abort_oe_up", 32'(ok), 32'd1);
        EBI_AD  = 16'h0033;
        EBI_ALE = 1'b1;
        repeat (4) @(negedge clk);
        check("ale_abort_oe", 32'(ebi_ad_oe), 32'd0);
        check("ale_abort_busy", 32'(busy), 32'd0);
        EBI_RE = 1'b1;
        repeat (2) @(negedge clk);
        mem_data = 16'h5A5A;
        EBI_ALE  = 1'b0;
        repeat (4) @(negedge clk);
        check("ale_next_busy", 32'(busy), 32'd1);
        wait_oe(lat, ok);
        check("ale_next_oe", 32'(ok), 32'd1);
        check("ale_next_data", 32'(ebi_ad_out), 32'h5A5A);
        check("ale_next_addr", 32'(rd_addr), 32'h0033);
        check("ale_next_bank", 32'(rd_bank), 32'd1);
        finish_read("ale_next", 16'h5A5A);

        // Status bank, scanline register.
        line_number = 10'd300;
        full_read("stat_line", 3'd7, 15'd0, 16'h012C, 4, 0);
        line_number = 10'd0;
        repeat (2) @(negedge clk);

        // Memory never answers: error word, then sticky flag read and cleared.
        mem_latency = 0;
        full_read("tmo", 3'd2, 15'h0040, 16'hDEAD, 18, 1);
        full_read("sticky_set", 3'd7, 15'd2, 16'h0002, 4, 0);
        full_read("sticky_clr", 3'd7, 15'd2, 16'h0000, 4, 0);
        full_read("stat_other", 3'd7, 15'd9, 16'h0000, 4, 0);

        // RE released one cycle after the strobe; late rd_valid is ignored.
        mem_latency = 4;
        mem_data    = 16'h7777;
        req0 = rdreq_count;
        issue_addr(3'd0, 15'h0055);
        EBI_RE = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_rd_req", 32'(ok), 32'd1);
        EBI_RE  = 1'b1;
        oe_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ebi_ad_oe !== 1'b0) oe_seen = 1'b1;
        end
        check("abort_oe_never", 32'(oe_seen), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_reqs", 32'(rdreq_count - req0), 32'd1);

        // Reset while driving.
        mem_latency = 2;
        mem_data    = 16'h1234;
        issue_addr(3'd4, 15'h0020);
        wait_oe(lat, ok);
        check("rdrive_oe_up", 32'(ok), 32'd1);
        check("rdrive_data", 32'(ebi_ad_out), 32'h1234);
        reset = 1'b1;
        @(negedge clk);
        check("rdrive_oe", 32'(ebi_ad_oe), 32'd0);
        check("rdrive_out", 32'(ebi_ad_out), 32'h0000);
        check("rdrive_busy", 32'(busy), 32'd0);
        check("rdrive_rd_addr", 32'(rd_addr), 32'd0);
        EBI_RE = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Frame counter wrap from reset.
        frame_pulse = 1'b1;
        repeat (65536) @(negedge clk);
        frame_pulse = 1'b0;
        full_read("frame_wrap", 3'd7, 15'd1, 16'h0000, 4, 0);
        frame_pulse = 1'b1;
        @(negedge clk);
        frame_pulse = 1'b0;
        full_read("frame_one", 3'd7, 15'd1, 16'h0001, 4, 0);

        // Vertical blank flag follows frame_pulse and line 0.
        line_number = 10'd300;
        frame_pulse = 1'b1;
        @(negedge clk);
        frame_pulse = 1'b0;
        full_read("vblank_set", 3'd7, 15'd2, 16'h0001, 4, 0);
        line_number = 10'd0;
        repeat (2) @(negedge clk);
        full_read("vblank_clr", 3'd7, 15'd2, 16'h0000, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
